// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request at a time: req/ready handshake on the address, rvalid on the data.
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs one imem transaction at a time,
// buffers the returned word and presents it to the IF/ID register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               stall,
  input  logic                     br,
  input  logic [31:0]              br_target,
  if_fetch_stage_if.master         imem,
  output logic [31:0]              pc_if,
  output logic [31:0]              inst_if,
  output logic                     inst_valid_if,
  output logic                     stallreq_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        drop, drop_n;
  logic [31:0] buffer;
  logic        load;
  logic        consume;

  // Only the PC/IF hold bit and the word-aligned part of the target matter here.
  logic unused_inputs;
  assign unused_inputs = ^{stall[4:1], br_target[1:0]};

  assign consume = (state == FULL) && !stall[0] && !br;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
    end
  end

  // NOTE: the instruction buffer has no reset; its contents are only visible
  // when state == FULL, which is reachable only after a load.
  always_ff @(posedge clk) begin
    if (load) buffer <= imem.rdata;
  end

  // NOTE: every variable gets its default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    load    = 1'b0;

    if (br) begin
      // A redirect wins over stall and over any data landing this cycle.
      pc_n = {br_target[31:2], 2'b00};
      unique case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (imem.ready) begin
            state_n = WAIT;
            drop_n  = 1'b1;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            state_n = REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end
        FULL: state_n = REQ;
        default: state_n = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (imem.ready) state_n = WAIT;
        end
        WAIT: begin
          if (imem.rvalid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = REQ;
            end else begin
              load    = 1'b1;
              state_n = FULL;
            end
          end
        end
        FULL: begin
          if (consume) begin
            pc_n    = pc + 32'd4;
            state_n = REQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // All outputs decode from registered state, so imem.rdata never reaches
  // inst_if combinationally.
  assign imem.req      = (state == REQ);
  assign imem.addr     = pc;
  assign inst_valid_if = (state == FULL);
  assign stallreq_if   = ~inst_valid_if;
  assign pc_if         = inst_valid_if ? pc : 32'h0000_0000;
  assign inst_if       = inst_valid_if ? buffer : BUBBLE_INST;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: drives the imem bus by hand and checks
// every output against hand-computed values after each clock edge.
module tb_if_fetch_stage;
  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [4:0]  stall;
  logic        br;
  logic [31:0] br_target;
  logic [31:0] pc_if;
  logic [31:0] inst_if;
  logic        inst_valid_if;
  logic        stallreq_if;

  int n_cmp;
  int n_err;

  if_fetch_stage_if imem ();

  if_fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .BUBBLE_INST (BUBBLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .br            (br),
    .br_target     (br_target),
    .imem          (imem.master),
    .pc_if         (pc_if),
    .inst_if       (inst_if),
    .inst_valid_if (inst_valid_if),
    .stallreq_if   (stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"},    {31'd0, inst_valid_if}, 32'd0);
    check({tag, ".stallreq"}, {31'd0, stallreq_if},   32'd1);
    check({tag, ".pc_if"},    pc_if,                  32'd0);
    check({tag, ".inst_if"},  inst_if,                BUBBLE);
  endtask

  task automatic check_full(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, ".valid"},    {31'd0, inst_valid_if}, 32'd1);
    check({tag, ".stallreq"}, {31'd0, stallreq_if},   32'd0);
    check({tag, ".pc_if"},    pc_if,                  pc);
    check({tag, ".inst_if"},  inst_if,                inst);
    check({tag, ".req"},      {31'd0, imem.req},      32'd0);
  endtask

  task automatic check_req(input string tag, input logic [31:0] addr);
    check({tag, ".req"},  {31'd0, imem.req}, 32'd1);
    check({tag, ".addr"}, imem.addr,         addr);
    check_empty(tag);
  endtask

  // From REQ: accept next cycle, respond the cycle after; leaves the DUT in FULL.
  task automatic fetch(input logic [31:0] data);
    imem.ready = 1'b1;
    step();
    imem.ready  = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata  = data;
    step();
    imem.rvalid = 1'b0;
    imem.rdata  = 32'hDEAD_BEEF;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset       = 1'b0;
    stall       = 5'd0;
    br          = 1'b0;
    br_target   = 32'd0;
    imem.ready  = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'hDEAD_BEEF;

    // Reset values.
    step();
    check("rst.req",  {31'd0, imem.req}, 32'd0);
    check("rst.addr", imem.addr,         32'd0);
    check_empty("rst");

    // IDLE for one cycle, then REQ at RESET_PC.
    reset = 1'b1;
    step();
    check_req("req0", 32'd0);
    imem.ready = 1'b1;
    step();
    check("wait0.req", {31'd0, imem.req}, 32'd0);
    check_empty("wait0");
    imem.ready  = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h0010_0093;
    step();
    imem.rvalid = 1'b0;
    check_full("full0", 32'd0, 32'h0010_0093);
    step();
    check_req("req4", 32'd4);

    // Consume pc 4, fetch pc 8 and hold it under stall.
    fetch(32'h0020_0113);
    check_full("full4", 32'd4, 32'h0020_0113);
    step();
    check_req("req8", 32'd8);
    fetch(32'h0030_0193);
    stall = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      step();
      check_full("stall8", 32'd8, 32'h0030_0193);
    end
    stall = 5'd0;
    step();
    check_req("req12", 32'd12);
    fetch(32'h0040_0213);
    step();
    check_req("req16", 32'd16);

    // Redirect while WAIT for addr 16: response discarded, next request at 0x100.
    imem.ready = 1'b1;
    step();
    imem.ready = 1'b0;
    br         = 1'b1;
    br_target  = 32'h0000_0103;
    step();
    br = 1'b0;
    check("brwait.req", {31'd0, imem.req}, 32'd0);
    check_empty("brwait");
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hBAD0_0016;
    step();
    imem.rvalid = 1'b0;
    check_req("req100", 32'h0000_0100);

    // Redirect coincident with rvalid in WAIT.
    imem.ready = 1'b1;
    step();
    imem.ready  = 1'b0;
    br          = 1'b1;
    br_target   = 32'h0000_0200;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hBAD0_0100;
    step();
    br          = 1'b0;
    imem.rvalid = 1'b0;
    check_req("req200", 32'h0000_0200);

    // Redirect in REQ with ready low: address switches, no drop.
    br        = 1'b1;
    br_target = 32'h0000_0301;
    step();
    br = 1'b0;
    check_req("req300", 32'h0000_0300);
    fetch(32'h0050_0293);
    check_full("full300", 32'h0000_0300, 32'h0050_0293);

    // Redirect in FULL overrides stall; then wrap from 0xFFFF_FFFC.
    br        = 1'b1;
    br_target = 32'hFFFF_FFFE;
    stall     = 5'b00001;
    step();
    br    = 1'b0;
    stall = 5'd0;
    check_req("reqfffc", 32'hFFFF_FFFC);
    fetch(32'h0060_0313);
    check_full("fullfffc", 32'hFFFF_FFFC, 32'h0060_0313);
    step();
    check_req("reqwrap", 32'd0);

    // Reset mid-WAIT with a stale response arriving during reset, IDLE and REQ.
    imem.ready = 1'b1;
    step();
    imem.ready = 1'b0;
    reset      = 1'b0;
    #1;
    check("arst.req",  {31'd0, imem.req}, 32'd0);
    check("arst.addr", imem.addr,         32'd0);
    check_empty("arst");
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hBAD0_0000;
    step();
    check("arst2.req", {31'd0, imem.req}, 32'd0);
    check_empty("arst2");
    reset = 1'b1;
    step();
    check_req("stale_idle", 32'd0);
    step();
    check_req("stale_req", 32'd0);
    imem.rvalid = 1'b0;
    fetch(32'h0070_0393);
    check_full("post_rst", 32'd0, 32'h0070_0393);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
